// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//
// Instruction fetch front-end sitting between the PC / instruction memory and
// the IF/ID pipeline register. It walks sequential fetch addresses, issues
// requests to a one-cycle-latency instruction memory, buffers each returned
// instruction together with its PC in a small FIFO, and presents the FIFO head
// to decode. A redirect flushes everything (buffered and in flight) and
// restarts fetch at the target.
//
// Handshakes:
//   imem_req / imem_req_ready : a request transfers in any cycle where both
//     are high; the instruction for it appears on imem_rsp_data exactly one
//     cycle later. imem_req never depends on imem_req_ready.
//   out_valid / out_ready     : an entry is consumed in any cycle where both
//     are high (and no redirect). out_valid never depends on out_ready, and
//     once raised stays up with stable data until consumed or flushed.
//
// Ports:
//   clk            in   clock, all state on the rising edge
//   reset          in   asynchronous active-high reset
//   redirect       in   flush and restart fetch at redirect_pc
//   redirect_pc    in   [63:0] redirect target (bits [1:0] ignored)
//   imem_req       out  fetch request valid
//   imem_addr      out  [63:0] fetch address
//   imem_req_ready in   memory accepts the request this cycle
//   imem_rsp_data  in   [31:0] instruction, one cycle after an accepted request
//   out_valid      out  instruction available to decode
//   out_pc         out  [63:0] PC of presented instruction (0 when empty)
//   out_instr      out  [31:0] presented instruction (0 when empty)
//   out_ready      in   decode consumes (not-stall)
//   count          out  [clog2(DEPTH):0] FIFO occupancy
//
// Configuration:
//   FETCHQ_BYPASS_EN  when defined, a response arriving into an empty FIFO is
//                     presented to decode in the same cycle; if decode takes
//                     it, it is never written into the FIFO.
// -----------------------------------------------------------------------------
module fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     redirect,
   input  logic [63:0]              redirect_pc,
   output logic                     imem_req,
   output logic [63:0]              imem_addr,
   input  logic                     imem_req_ready,
   input  logic [31:0]              imem_rsp_data,
   output logic                     out_valid,
   output logic [63:0]              out_pc,
   output logic [31:0]              out_instr,
   input  logic                     out_ready,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

   logic [63:0]   r_fetch_pc;
   logic          r_inflight;
   logic [63:0]   r_inflight_pc;
   logic [63:0]   r_pc_mem    [DEPTH];
   logic [31:0]   r_instr_mem [DEPTH];
   logic [AW-1:0] r_head;
   logic [AW-1:0] r_tail;
   logic [CW-1:0] r_count;

   logic [CW:0]   w_occ;
   logic          w_accept;
   logic          w_rsp;
   logic          w_empty;
   logic          w_byp;
   logic          w_push;
   logic          w_pop;
   logic [63:0]   w_target;

   // Occupancy includes the in-flight request so a returning response always
   // has a free slot; the FIFO therefore never needs a full check on push.
   assign w_occ     = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
   assign imem_req  = !redirect && (w_occ < DEPTH_W);
   assign imem_addr = r_fetch_pc;
   assign w_accept  = imem_req && imem_req_ready;
   assign w_rsp     = r_inflight && !redirect;
   assign w_empty   = (r_count == '0);
   assign w_target  = redirect_pc & ~64'h3;

`ifdef FETCHQ_BYPASS_EN
   assign w_byp  = w_empty && w_rsp;
   // A bypassed instruction taken by decode this cycle skips the FIFO.
   assign w_push = w_rsp && !(w_byp && out_ready);
`else
   assign w_byp  = 1'b0;
   assign w_push = w_rsp;
`endif

   // Redirect suppresses consumption even though out_valid may still be high.
   assign w_pop     = !w_empty && out_ready && !redirect;
   assign out_valid = !w_empty || w_byp;
   assign count     = r_count;

   always_comb begin
      out_pc    = 64'h0;
      out_instr = 32'h0;
      if (!w_empty) begin
         out_pc    = r_pc_mem[r_head];
         out_instr = r_instr_mem[r_head];
      end else if (w_byp) begin
         out_pc    = r_inflight_pc;
         out_instr = imem_rsp_data;
      end
   end

   // Storage needs no reset: entries are only visible through r_count.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_pc_mem[r_tail]    <= r_inflight_pc;
         r_instr_mem[r_tail] <= imem_rsp_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_fetch_pc    <= RESET_PC;
         r_inflight    <= 1'b0;
         r_inflight_pc <= 64'h0;
         r_head        <= '0;
         r_tail        <= '0;
         r_count       <= '0;
      end else if (redirect) begin
         r_fetch_pc <= w_target;
         r_inflight <= 1'b0;
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= '0;
      end else begin
         if (w_accept) begin
            r_fetch_pc    <= r_fetch_pc + 64'd4;
            r_inflight_pc <= r_fetch_pc;
         end
         r_inflight <= w_accept;
         if (w_push) r_tail <= r_tail + 1'b1;
         if (w_pop)  r_head <= r_head + 1'b1;
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

   localparam int          DEPTH    = 4;
   localparam logic [63:0] RESET_PC = 64'h0;
`ifdef FETCHQ_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] instr;
   } entry_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        redirect;
   logic [63:0] redirect_pc;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_req_ready;
   logic [31:0] imem_rsp_data;
   logic        out_valid;
   logic [63:0] out_pc;
   logic [31:0] out_instr;
   logic        out_ready;
   logic [$clog2(DEPTH):0] count;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: fetch pointer, one optional outstanding request, and
   // an ordered queue of delivered-but-unconsumed instructions.
   logic [63:0] m_fetch_pc;
   bit          m_inf;
   logic [63:0] m_inf_pc;
   entry_t      m_q[$];
   logic [63:0] got_q[$];

   fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_req_ready(imem_req_ready),
      .imem_rsp_data(imem_rsp_data), .out_valid(out_valid), .out_pc(out_pc),
      .out_instr(out_instr), .out_ready(out_ready), .count(count)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   // Memory contents as a function of address.
   function automatic logic [31:0] instr_of(input logic [63:0] a);
      return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0000_0013;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_inf      = 1'b0;
      m_inf_pc   = 64'h0;
      m_fetch_pc = RESET_PC;
   endtask

   // Called with inputs already set, at a point where DUT outputs are settled
   // for the current cycle. Checks, advances the model, then moves to just
   // after the next rising edge and drives the memory response.
   task automatic step();
      bit          e_req, e_byp, e_valid;
      logic [63:0] e_pc;
      logic [31:0] e_instr, rsp_next;
      int          occ;
      occ   = m_q.size() + int'(m_inf);
      e_req = !redirect && (occ < DEPTH);
      e_byp = 1'b0;
`ifdef FETCHQ_BYPASS_EN
      e_byp = (m_q.size() == 0) && m_inf && !redirect;
`endif
      e_valid = (m_q.size() != 0) || e_byp;
      e_pc    = 64'h0;
      e_instr = 32'h0;
      if (m_q.size() != 0) begin
         e_pc    = m_q[0].pc;
         e_instr = m_q[0].instr;
      end else if (e_byp) begin
         e_pc    = m_inf_pc;
         e_instr = instr_of(m_inf_pc);
      end
      chk("imem_req",  imem_req,  e_req);
      chk("imem_addr", imem_addr, m_fetch_pc);
      chk("out_valid", out_valid, e_valid);
      chk("out_pc",    out_pc,    e_pc);
      chk("out_instr", out_instr, e_instr);
      chk("count",     count,     64'(m_q.size()));

      if (imem_req && imem_req_ready) rsp_next = instr_of(imem_addr);
      else                            rsp_next = $urandom;

      if (redirect) begin
         m_q.delete();
         m_inf      = 1'b0;
         m_fetch_pc = {redirect_pc[63:2], 2'b00};
      end else begin
         if (m_q.size() != 0 && out_ready) void'(m_q.pop_front());
         if (m_inf && !(e_byp && out_ready)) m_q.push_back('{pc: m_inf_pc, instr: instr_of(m_inf_pc)});
         if (e_req && imem_req_ready) begin
            m_inf      = 1'b1;
            m_inf_pc   = m_fetch_pc;
            m_fetch_pc = m_fetch_pc + 64'd4;
         end else begin
            m_inf = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      imem_rsp_data = rsp_next;
   endtask

   task automatic tick();
      @(negedge clk);
      step();
   endtask

   // Asynchronous reset: outputs must fall back before any clock edge.
   task automatic do_reset();
      reset = 1'b1;
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_imem_addr", imem_addr, RESET_PC);
      chk("rst_count",     count,     0);
      chk("rst_out_pc",    out_pc,    0);
      chk("rst_out_instr", out_instr, 0);
      chk("rst_imem_req",  imem_req,  !redirect);
      model_reset();
      @(posedge clk);
      #1;
      reset         = 1'b0;
      imem_rsp_data = $urandom;
   endtask

   initial begin
      logic [63:0] rpc;
      int          guard;
      bit          rdy_pat [7];
      logic [63:0] addr_pat [7];
      rdy_pat  = '{1, 1, 0, 0, 1, 1, 1};
      addr_pat = '{64'd0, 64'd4, 64'd8, 64'd8, 64'd8, 64'd12, 64'd16};

      reset = 1'b1; redirect = 1'b0; redirect_pc = 64'h0;
      imem_req_ready = 1'b1; imem_rsp_data = 32'h0; out_ready = 1'b1;

      // Streaming from reset: addresses 0,4,8,..., output after LAT cycles.
      do_reset();
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         chk("t1_addr", imem_addr, 64'(4 * c));
         chk("t1_valid", out_valid, c >= LAT);
         if (c >= LAT) chk("t1_pc", out_pc, 64'(4 * (c - LAT)));
         step();
      end

      // Decode stalls: FIFO fills to DEPTH, requests stop, nothing lost.
      do_reset();
      out_ready = 1'b0;
      for (int c = 0; c < 10; c++) tick();
      @(negedge clk);
      chk("t2_full_count", count, DEPTH);
      chk("t2_full_req", imem_req, 1'b0);
      step();
      out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("t2_seq_pc", out_pc, 64'(4 * k));
         chk("t2_seq_valid", out_valid, 1'b1);
         step();
      end

      // Redirect with three queued entries and one request in flight.
      do_reset();
      out_ready = 1'b0;
      guard = 0;
      while (!(m_q.size() == 3 && m_inf) && guard < 20) begin
         tick();
         guard++;
      end
      chk("t3_setup_count", count, 3);
      redirect = 1'b1; redirect_pc = 64'h100;
      tick();
      redirect = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      chk("t3_flush_count", count, 0);
      chk("t3_flush_valid", out_valid, 1'b0);
      chk("t3_target_addr", imem_addr, 64'h100);
      chk("t3_target_req", imem_req, 1'b1);
      step();
      for (int c = 0; c < 6; c++) tick();

      // Misaligned target is forced to word alignment.
      redirect = 1'b1; redirect_pc = 64'h203;
      tick();
      redirect = 1'b0;
      @(negedge clk);
      chk("t4_aligned_addr", imem_addr, 64'h200);
      step();
      for (int c = 0; c < 4; c++) tick();

      // Memory back-pressure: address 8 held while not accepted.
      do_reset();
      got_q.delete();
      for (int c = 0; c < 12; c++) begin
         imem_req_ready = (c < 7) ? rdy_pat[c] : 1'b1;
         @(negedge clk);
         if (c < 7) chk("t5_addr", imem_addr, addr_pat[c]);
         if (out_valid && out_ready) got_q.push_back(out_pc);
         step();
      end
      chk("t5_got_len", 64'(got_q.size() >= 4), 1'b1);
      for (int k = 0; k < 4 && k < got_q.size(); k++) chk("t5_order", got_q[k], 64'(4 * k));

      // Wrap-around of the 64-bit PC.
      redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8;
      tick();
      redirect = 1'b0;
      for (int c = 0; c < 6; c++) tick();

      // Reset while entries are queued.
      out_ready = 1'b0;
      guard = 0;
      while (m_q.size() != 3 && guard < 20) begin
         tick();
         guard++;
      end
      chk("t6_setup_count", count, 3);
      do_reset();
      out_ready = 1'b1;
      for (int c = 0; c < 4; c++) tick();

      // Randomized traffic against the model.
      for (int c = 0; c < 2000; c++) begin
         out_ready      = ($urandom_range(0, 3) != 0);
         imem_req_ready = ($urandom_range(0, 3) != 0);
         redirect       = ($urandom_range(0, 24) == 0);
         rpc            = {$urandom, $urandom};
         if ($urandom_range(0, 2) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF0 | {60'h0, rpc[3:0]};
         redirect_pc    = rpc;
         if ($urandom_range(0, 299) == 0) do_reset();
         else tick();
      end
      redirect = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
